serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing diff = a - b, one bit per clock, LSB first, with a ripple borrow held in a flip-flop.
- It is the inverse arithmetic counterpart of the half_adder cell: the subtraction datapath built from half-subtractor cells plus sequential control.
- Start/busy/done handshake.
- Sits beside the adder cells as the area-cheap subtract unit for multi-cycle arithmetic paths.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- diff  output  WIDTH  result a-b mod 2^WIDTH; valid when done=1 and held until the next accepted start.
- borrow_out  output  1  final borrow; 1 iff a<b unsigned; valid and held with diff.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking diff/borrow_out valid.

Behaviour:
- Reset: clk is the one clock. rst is asynchronous and active-high and takes effect immediately, without waiting for a clock edge. While rst is high:
  - diff=0, borrow_out=0, busy=0, done=0.
  - State=IDLE; bit counter=0; internal borrow=0; operand shift registers=0.
- States:
  - IDLE: busy=0. On start=1 at a rising edge: load sa<=a, sb<=b, bor<=0, cnt<=0, result shift register<=0, go to SHIFT.
  - SHIFT: busy=1. Each edge does four things:
    - d = sa[0]^sb[0]^bor.
    - bor <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bor).
    - The result register shifts right, with d entering at the MSB.
    - sa and sb shift right by one; cnt <= cnt+1.
    - When cnt==WIDTH-1 on that edge, go to DONE.
  - DONE: busy=0, done=1 for exactly this one cycle. diff equals the result register; borrow_out equals the final bor. Next edge goes to IDLE, or to SHIFT if start=1, so back-to-back operations are accepted.
- Latency:
  - The start is accepted at edge k.
  - Edges k+1..k+WIDTH perform the WIDTH bit steps.
  - done is high in the cycle following edge k+WIDTH.
  - The next start can be accepted at edge k+WIDTH+1 at the earliest.
- Handshake:
  - start while busy=1 is ignored. It is neither queued nor able to corrupt the operands.
  - a and b may change freely after the accepting edge.
- Output hold: diff and borrow_out are updated only on entry to DONE. They keep their value through IDLE and through a following SHIFT, until the next DONE.
- Counter: width is clog2(WIDTH) bits. cnt never exceeds WIDTH-1. It is cleared on every accepted start.
- Arithmetic: diff equals (a - b) mod 2^WIDTH, i.e. a + ~b + 1 truncated. borrow_out equals the inverse of the carry of that sum.
- Boundaries:
  - a==b gives diff=0, borrow_out=0.
  - a=0 with b>0 gives a wrap-around result and borrow_out=1.
  - Simultaneous start and rst: rst wins.
- Reset mid-operation: rst asserted during SHIFT aborts immediately. All outputs return to their reset values, and no done pulse is produced for the aborted operation.

Decomposition:
- Shared package: state encoding constants S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2; default width constant 8.
- One natural sub-module: full_subtractor, with inputs x, y, bin and outputs d, bout. It is built from two half-subtractor cells and an OR for bout. It is instantiated once, combinationally, on sa[0], sb[0], bor.
- The FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- Basic subtraction: rst pulse, then a=8'd5, b=8'd3, start for 1 cycle -> busy high for 8 cycles; done pulse one cycle at edge 9 after start; diff=8'd2, borrow_out=0.
- Wrap-around: a=8'd3, b=8'd5 -> diff=8'd254, borrow_out=1. Then a=0, b=1 -> diff=8'd255, borrow_out=1.
- Edge values: a=b=8'd255 -> diff=0, borrow_out=0. a=8'd255, b=0 -> diff=8'd255, borrow_out=0.
- Start ignored while busy: start held high throughout with a=8'd100, b=8'd1; change a,b to 8'd7,8'd9 mid-SHIFT.
  - First done shows diff=8'd99.
  - Back-to-back restart from DONE captures 7,9 -> next done diff=8'd254, borrow_out=1.
- Reset mid-operation: start a=8'd40, b=8'd2; assert rst asynchronously after 4 cycles -> diff, borrow_out, busy, done go to 0 immediately. No done pulse appears after rst is released.
- Randomized check: 200 random a,b pairs with WIDTH=8, plus one pass with WIDTH=16 -> each done gives diff==(a-b) mod 2^WIDTH and borrow_out==(a<b).

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : FSM state encoding (IDLE / SHIFT / DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from two half-subtractor cells.
//   half_subtractor : x, y -> d = x ^ y, b = ~x & y
//   full_subtractor : x, y, bin -> d = x ^ y ^ bin, bout = borrow out
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);
    assign d = x ^ y;
    assign b = ~x & y;
endmodule

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (.x(x),  .y(y),   .d(d1), .b(b1));
    half_subtractor u_hs1 (.x(d1), .y(bin), .d(d),  .b(b2));

    // Borrow from either stage propagates; both cannot be set at once.
    assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : begin an operation (accepted only when not busy)
//   a, b       : minuend / subtrahend, captured on the accepting edge
//   diff       : result mod 2^WIDTH, held until the next completion
//   borrow_out : 1 iff a < b, held with diff
//   busy       : operation in progress
//   done       : one-cycle pulse when diff/borrow_out are updated
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | one bit of the difference produced per edge
// DONE   | result valid pulse; start here restarts immediately
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             bor;
    logic             d_bit;
    logic             bor_nxt;
    logic             load;
    logic             last;

    full_subtractor u_fs (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (bor),
        .d    (d_bit),
        .bout (bor_nxt)
    );

    assign last = (state == S_SHIFT) && (cnt == LAST);
    assign load = ((state == S_IDLE) || (state == S_DONE)) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_SHIFT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            cnt        <= '0;
            bor        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            res <= '0;
            cnt <= '0;
            bor <= 1'b0;
        end else if (state == S_SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= {d_bit, res[WIDTH-1:1]};
            bor <= bor_nxt;
            // Wrap to zero on the last bit so cnt never reaches WIDTH.
            cnt <= last ? '0 : cnt + CW'(1);
            if (last) begin
                diff       <= {d_bit, res[WIDTH-1:1]};
                borrow_out <= bor_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, diff8;
    logic        bo8, busy8, done8;
    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, diff16;
    logic        bo16, busy16, done16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .diff(diff8), .borrow_out(bo8), .busy(busy8), .done(done8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .diff(diff16), .borrow_out(bo16), .busy(busy16), .done(done16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dout(input int w);
        return (w == 8) ? {24'b0, diff8} : {16'b0, diff16};
    endfunction
    function automatic logic dn(input int w);
        return (w == 8) ? done8 : done16;
    endfunction
    function automatic logic bsy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction
    function automatic logic bout(input int w);
        return (w == 8) ? bo8 : bo16;
    endfunction

    // Reference: plain modular arithmetic on the captured operands.
    task automatic op(input int w, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] mask, prev, expd;
        int n, nb;
        mask = (32'd1 << w) - 32'd1;
        prev = dout(w);
        if (w == 8) begin a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1; end
        else begin a16 = av[15:0]; b16 = bv[15:0]; start16 = 1'b1; end
        step();
        start8 = 1'b0; start16 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom);
        check("hold_in_shift", dout(w), prev);
        n = 0; nb = 0;
        while (!dn(w) && n < 64) begin
            if (bsy(w)) nb++;
            step();
            n++;
        end
        check("latency", n, w);
        check("busy_cycles", nb, w);
        expd = (av - bv) & mask;
        check("diff", dout(w), expd);
        check("borrow", {31'b0, bout(w)}, {31'b0, ((av & mask) < (bv & mask))});
        step();
        check("done_pulse", {31'b0, dn(w)}, 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        #1;
        check("rst_diff", {24'b0, diff8}, 0);
        check("rst_borrow", {31'b0, bo8}, 0);
        check("rst_busy", {31'b0, busy8}, 0);
        check("rst_done", {31'b0, done8}, 0);
        step(); step();
        rst = 1'b0;
        step();

        op(8, 5, 3);
        step();
        check("hold_idle", {24'b0, diff8}, 2);
        op(8, 3, 5);
        op(8, 0, 1);
        op(8, 255, 255);
        op(8, 255, 0);

        // Start held high: busy ignores it, DONE restarts with new operands.
        a8 = 8'd100; b8 = 8'd1; start8 = 1'b1;
        step();
        step(); step(); step();
        a8 = 8'd7; b8 = 8'd9;
        n = 0;
        while (!done8 && n < 64) begin step(); n++; end
        check("held_diff", {24'b0, diff8}, 99);
        check("held_borrow", {31'b0, bo8}, 0);
        step();
        check("restart_busy", {31'b0, busy8}, 1);
        check("restart_done", {31'b0, done8}, 0);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 64) begin step(); n++; end
        check("b2b_diff", {24'b0, diff8}, 254);
        check("b2b_borrow", {31'b0, bo8}, 1);
        step();

        // Asynchronous reset in the middle of SHIFT.
        a8 = 8'd40; b8 = 8'd2; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step(); step();
        #2 rst = 1'b1;
        #1;
        check("abort_diff", {24'b0, diff8}, 0);
        check("abort_borrow", {31'b0, bo8}, 0);
        check("abort_busy", {31'b0, busy8}, 0);
        check("abort_done", {31'b0, done8}, 0);
        start8 = 1'b1;
        step();
        check("rst_wins_busy", {31'b0, busy8}, 0);
        start8 = 1'b0;
        #3 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 || busy8) seen = 1'b1;
        end
        check("no_done_after_abort", {31'b0, seen}, 0);

        for (int i = 0; i < 200; i++)
            op(8, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)));
        op(16, 0, 16'hffff);
        for (int i = 0; i < 30; i++)
            op(16, 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
